// File: rtl/lsu_mem_ctrl_pkg.sv
// +------------------------------------------------------------------------+
// | Module   : lsu_mem_ctrl_pkg                                            |
// | Brief    : Shared encodings and helpers for the LSU memory controller  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

package lsu_mem_ctrl_pkg;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  // Memory strobes are active-low.
  localparam logic WRITE_ENABLE = 1'b0;
  localparam logic READ_ENABLE  = 1'b0;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_ACCESS = 3'd1,
    LSU_RMW_RD = 3'd2,
    LSU_RMW_WR = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_e;

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == LSU_SIZE_BYTE) || (size == LSU_SIZE_HALF);
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] r;
    case (size)
      LSU_SIZE_BYTE: r = off;
      LSU_SIZE_HALF: r = {off[1], 1'b0};
      default:       r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      LSU_SIZE_BYTE: r = 1'b0;
      LSU_SIZE_HALF: r = off[0];
      default:       r = |off;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_data_align.sv
// +------------------------------------------------------------------------+
// | Module   : lsu_data_align                                              |
// | Brief    : Load lane extract/extend and store lane merge (comb only)   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module lsu_data_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_rword,
  input  logic [15:0]       i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_rword[{i_off, 3'b000} +: 8];
    w_half  = i_rword[{i_off[1], 4'b0000} +: 16];
    o_load  = i_rword;
    o_merge = i_rword;
    case (i_size)
      LSU_SIZE_BYTE: begin
        o_load = {{(DATA_W-8){~i_unsigned & w_byte[7]}}, w_byte};
        o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      LSU_SIZE_HALF: begin
        o_load = {{(DATA_W-16){~i_unsigned & w_half[15]}}, w_half};
        o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// +------------------------------------------------------------------------+
// | Module   : lsu_mem_ctrl                                                |
// | Brief    : Load/store controller for a word-addressed, strobe-driven   |
// |            memory; sub-word stores run as read-modify-write.           |
// |            Optional MISALIGN_TRAP_EN traps misaligned half/word access.|
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 5
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_WRn,
  output logic              mem_RDn,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_DIN,
  input  logic [DATA_W-1:0] mem_DOUT
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_trap;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [15:0]       r_wdata;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;
  logic              w_unused_addr;

  assign w_unused_addr = ^req_addr[31:MEM_AW+2];
  assign req_ready     = (r_state == LSU_IDLE);
  assign w_accept      = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  assign w_trap   = is_misaligned(req_size, req_addr[1:0]);
  assign resp_err = r_err;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_err <= 1'b0;
    end else if (w_accept && w_trap) begin
      r_err <= 1'b1;
    end else if (r_state == LSU_ACCESS || r_state == LSU_RMW_WR) begin
      r_err <= 1'b0;
    end
  end
`else
  assign w_trap   = 1'b0;
  assign resp_err = 1'b0;
`endif

  lsu_data_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_off),
    .i_rword    (mem_DOUT),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= LSU_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          if (w_trap)                               w_state_nxt = LSU_RESP;
          else if (req_we && is_sub_word(req_size)) w_state_nxt = LSU_RMW_RD;
          else                                      w_state_nxt = LSU_ACCESS;
        end
      end
      LSU_ACCESS: w_state_nxt = LSU_RESP;
      LSU_RMW_RD: w_state_nxt = LSU_RMW_WR;
      LSU_RMW_WR: w_state_nxt = LSU_RESP;
      LSU_RESP:   w_state_nxt = LSU_IDLE;
      default:    w_state_nxt = LSU_IDLE;
    endcase
  end

  // mem_DIN doubles as the merge register: the merged word is formed while
  // the read strobe is active and registered straight onto the write bus.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_we       <= 1'b0;
      r_size     <= LSU_SIZE_WORD;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_WRn    <= ~WRITE_ENABLE;
      mem_RDn    <= ~READ_ENABLE;
      mem_addr   <= '0;
      mem_DIN    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= align_off(req_size, req_addr[1:0]);
            r_wdata    <= req_wdata[15:0];
            mem_addr   <= req_addr[MEM_AW+1:2];
            if (w_trap) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && !is_sub_word(req_size)) begin
              mem_WRn <= WRITE_ENABLE;
              mem_DIN <= req_wdata;
            end else begin
              mem_RDn <= READ_ENABLE;
            end
          end
        end
        LSU_ACCESS: begin
          mem_WRn    <= ~WRITE_ENABLE;
          mem_RDn    <= ~READ_ENABLE;
          resp_valid <= 1'b1;
          resp_rdata <= r_we ? '0 : w_load;
        end
        LSU_RMW_RD: begin
          mem_RDn <= ~READ_ENABLE;
          mem_WRn <= WRITE_ENABLE;
          mem_DIN <= w_merge;
        end
        LSU_RMW_WR: begin
          mem_WRn    <= ~WRITE_ENABLE;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// +------------------------------------------------------------------------+
// | Module   : tb_lsu_mem_ctrl                                             |
// | Brief    : Scoreboard bench for lsu_mem_ctrl with a behavioural memory |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_ctrl;

  logic        CLK;
  logic        RSTn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WRn;
  logic        mem_RDn;
  logic [4:0]  mem_addr;
  logic [31:0] mem_DIN;
  logic [31:0] mem_DOUT;

  lsu_mem_ctrl #(
    .DATA_W (32),
    .MEM_AW (5)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_WRn      (mem_WRn),
    .mem_RDn      (mem_RDn),
    .mem_addr     (mem_addr),
    .mem_DIN      (mem_DIN),
    .mem_DOUT     (mem_DOUT)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          fails   = 0;
  int          cyc     = 0;
  int          wr_cnt  = 0;
  logic        mem_init;
  logic [31:0] mem [0:31];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Word memory: combinational read, write on the edge while WRn is low.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 1) ? 32'h12345678 : 32'h0;
    end else if (!mem_WRn) begin
      mem[mem_addr] <= mem_DIN;
    end
  end
  assign mem_DOUT = mem[mem_addr];

  always @(negedge CLK) if (!mem_WRn) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
  end

  // Drives a request at a falling edge and returns at the falling edge of C1.
  task automatic issue(input string nm, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic push, input logic [31:0] er, input logic ee,
                       input int lat, input logic hold, output int acc);
    int budget;
    budget       = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    while (!req_ready && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    acc = cyc;
    if (!req_ready) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      if (push) sb_q.push_back('{nm, er, ee, lat, cyc});
      @(negedge CLK);
      if (!hold) req_valid = 1'b0;
    end
  endtask

  initial begin
    int acc1;
    int acc2;
    int wr_snap;
    int t;

    RSTn = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_strobes", {30'd0, mem_WRn, mem_RDn}, 32'd3);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_DIN, 32'd0);
    RSTn = 1'b1; mem_init = 1'b0;
    @(negedge CLK);

    // word store then load back
    issue("sw_08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2, 1'b0, acc1);
    chk("sw_c1_wrn", {31'd0, mem_WRn}, 32'd0);
    chk("sw_c1_rdn", {31'd0, mem_RDn}, 32'd1);
    chk("sw_c1_addr", {27'd0, mem_addr}, 32'd2);
    chk("sw_c1_din", mem_DIN, 32'hDEADBEEF);
    issue("lw_08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, 1'b0, acc1);
    chk("lw_c1_rdn", {31'd0, mem_RDn}, 32'd0);

    // byte store as read-modify-write
    issue("sb_09", 1'b1, 2'b00, 1'b0, 32'h09, 32'h000000A5, 1'b1, 32'h0, 1'b0, 3, 1'b0, acc1);
    chk("sb_c1_rdn", {31'd0, mem_RDn}, 32'd0);
    chk("sb_c1_wrn", {31'd0, mem_WRn}, 32'd1);
    @(negedge CLK);
    chk("sb_c2_wrn", {31'd0, mem_WRn}, 32'd0);
    chk("sb_c2_rdn", {31'd0, mem_RDn}, 32'd1);
    chk("sb_c2_din", mem_DIN, 32'hDEADA5EF);

    // sub-word loads from 0xDEADA5EF
    issue("lb_09",  1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 1'b1, 32'hFFFFFFA5, 1'b0, 2, 1'b0, acc1);
    issue("lbu_09", 1'b0, 2'b00, 1'b1, 32'h09, 32'h0, 1'b1, 32'h000000A5, 1'b0, 2, 1'b0, acc1);
    issue("lh_0A",  1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0, 2, 1'b0, acc1);
    issue("lhu_0A", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 1'b1, 32'h0000DEAD, 1'b0, 2, 1'b0, acc1);
    issue("lb_08",  1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 1'b1, 32'hFFFFFFEF, 1'b0, 2, 1'b0, acc1);
    issue("lh_08",  1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 1'b1, 32'hFFFFA5EF, 1'b0, 2, 1'b0, acc1);

    // misaligned word load
`ifdef MISALIGN_TRAP_EN
    issue("lw_06_trap", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, acc1);
    chk("trap_c1_strobes", {30'd0, mem_WRn, mem_RDn}, 32'd3);
`else
    issue("lw_06_mask", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h12345678, 1'b0, 2, 1'b0, acc1);
    chk("mask_c1_addr", {27'd0, mem_addr}, 32'd1);
    chk("mask_c1_rdn", {31'd0, mem_RDn}, 32'd0);
`endif

    // upper half store, then word read and an aliased address
    issue("sh_0A", 1'b1, 2'b01, 1'b0, 32'h0A, 32'h00001234, 1'b1, 32'h0, 1'b0, 3, 1'b0, acc1);
    @(negedge CLK);
    chk("sh_c2_din", mem_DIN, 32'h1234A5EF);
    issue("lw_08b", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 32'h1234A5EF, 1'b0, 2, 1'b0, acc1);
    issue("lw_88_alias", 1'b0, 2'b10, 1'b0, 32'h88, 32'h0, 1'b1, 32'h1234A5EF, 1'b0, 2, 1'b0, acc1);
    issue("lbu_0B", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 1'b1, 32'h00000012, 1'b0, 2, 1'b0, acc1);

    // reset during C2 of a half store aborts the write
    issue("sh_rst", 1'b1, 2'b01, 1'b0, 32'h08, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 3, 1'b0, acc1);
    wr_snap = wr_cnt;
    @(posedge CLK);
    #1 RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_mid_wrn", {31'd0, mem_WRn}, 32'd1);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_no_write", wr_cnt - wr_snap, 32'd0);
    chk("rst_mid_word2", mem[2], 32'h1234A5EF);

    // req_valid held across two loads
    issue("lw_hold1", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 32'h1234A5EF, 1'b0, 2, 1'b1, acc1);
    chk("hold_c1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge CLK);
    chk("hold_c2_ready", {31'd0, req_ready}, 32'd0);
    issue("lw_hold2", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b1, 32'h12345678, 1'b0, 2, 1'b0, acc2);
    chk("hold_accept_spacing", acc2 - acc1, 32'd3);

    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
